// File: rtl/mach_pkg.sv
// -----------------------------------------------------------------------------
// mach_pkg
// Shared constants for the sequencing-machine receive-side monitor.
//   S0..S3        : 2-bit machine state codes {A,B}, A is the MSB.
//   FSM_*         : monitor FSM state encoding.
//   CL_*          : transition class produced by mach_step_classifier.
// -----------------------------------------------------------------------------
package mach_pkg;

  localparam logic [1:0] S0 = 2'b00;
  localparam logic [1:0] S1 = 2'b01;
  localparam logic [1:0] S2 = 2'b10;
  localparam logic [1:0] S3 = 2'b11;

  localparam logic [1:0] FSM_IDLE   = 2'd0;
  localparam logic [1:0] FSM_ACQ    = 2'd1;
  localparam logic [1:0] FSM_LOCKED = 2'd2;
  localparam logic [1:0] FSM_FAULT  = 2'd3;

  localparam logic [1:0] CL_HOLD = 2'd0;
  localparam logic [1:0] CL_UP   = 2'd1;
  localparam logic [1:0] CL_DOWN = 2'd2;
  localparam logic [1:0] CL_ILL  = 2'd3;

endpackage

// File: rtl/mach_step_classifier.sv
// -----------------------------------------------------------------------------
// mach_step_classifier
// Combinational classification of one transition of the 2-bit machine state.
// Ports:
//   i_prev  [1:0] previously sampled state
//   i_cur   [1:0] currently sampled state
//   o_cls   [1:0] transition class (CL_HOLD / CL_UP / CL_DOWN / CL_ILL)
// -----------------------------------------------------------------------------
module mach_step_classifier
  import mach_pkg::*;
(
  input  logic [1:0] i_prev,
  input  logic [1:0] i_cur,
  output logic [1:0] o_cls
);

  // Distance around the 4-state ring: 0 = hold, 1 = up, 3 = down, 2 = jump.
  logic [1:0] w_dist;
  assign w_dist = i_cur - i_prev;

  always_comb begin
    o_cls = CL_ILL;
    case (w_dist)
      2'd0:    o_cls = CL_HOLD;
      2'd1:    o_cls = CL_UP;
      2'd3:    o_cls = CL_DOWN;
      default: o_cls = CL_ILL;
    endcase
  end

endmodule

// File: rtl/mach_seq_monitor.sv
// -----------------------------------------------------------------------------
// mach_seq_monitor
// Receive-side checker for the sequencing machine's {A,B} state output.
// Classifies each enabled sample as hold / up / down / illegal, tracks a
// wrapping step position, counts illegal transitions, and runs a small
// IDLE/ACQ/LOCKED/FAULT status FSM.
// Ports:
//   clk, rst        rising-edge clock, synchronous active-high reset
//   en              sample enable
//   a, b            machine state MSB / LSB
//   step, hold, err one-cycle pulses for legal step / no change / illegal jump
//   dir             direction of last legal step (1 = up)
//   step_cnt        signed-style position, wraps mod 2^CNT_W
//   err_cnt         illegal transitions since reset, saturating at MAX_ERR
//   locked, fault   FSM in LOCKED / FAULT
// -----------------------------------------------------------------------------
module mach_seq_monitor
  import mach_pkg::*;
#(
  parameter int CNT_W    = 8,
  parameter int LOCK_LEN = 4,
  parameter int MAX_ERR  = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             a,
  input  logic             b,
  output logic             step,
  output logic             dir,
  output logic             hold,
  output logic             err,
  output logic [CNT_W-1:0] step_cnt,
  output logic [1:0]       err_cnt,
  output logic             locked,
  output logic             fault
);

  localparam int              RL_W       = $clog2(LOCK_LEN + 1);
  localparam logic [RL_W-1:0] LOCK_LEN_C = RL_W'(LOCK_LEN);
  localparam logic [1:0]      MAX_ERR_C  = 2'(MAX_ERR);

  logic [1:0]       r_prev;
  logic [1:0]       r_fsm;
  logic [RL_W-1:0]  r_run_len;
  logic [CNT_W-1:0] r_step_cnt;
  logic [1:0]       r_err_cnt;
  logic             r_step;
  logic             r_dir;
  logic             r_hold;
  logic             r_err;

  logic [1:0]       w_cur;
  logic [1:0]       w_cls;
  logic             w_up;
  logic             w_same_dir;
  logic [RL_W-1:0]  w_run_step;
  logic [1:0]       w_err_nxt;
  logic [CNT_W-1:0] w_cnt_step;

  function automatic logic [RL_W-1:0] sat_inc_run(input logic [RL_W-1:0] v);
    return (v == LOCK_LEN_C) ? v : v + 1'b1;
  endfunction

  function automatic logic [1:0] sat_inc_err(input logic [1:0] v);
    return (v == MAX_ERR_C) ? v : v + 1'b1;
  endfunction

  assign w_cur = {a, b};

  mach_step_classifier u_cls (
    .i_prev (r_prev),
    .i_cur  (w_cur),
    .o_cls  (w_cls)
  );

  assign w_up       = (w_cls == CL_UP);
  // run_len==0 marks the first step after IDLE or after an illegal jump,
  // which always restarts the run regardless of the stored direction.
  assign w_same_dir = (r_run_len != '0) && (w_up == r_dir);
  assign w_run_step = w_same_dir ? sat_inc_run(r_run_len) : RL_W'(1);
  assign w_err_nxt  = sat_inc_err(r_err_cnt);
  assign w_cnt_step = w_up ? r_step_cnt + 1'b1 : r_step_cnt - 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_prev     <= S0;
      r_fsm      <= FSM_IDLE;
      r_run_len  <= '0;
      r_step_cnt <= '0;
      r_err_cnt  <= '0;
      r_step     <= 1'b0;
      r_dir      <= 1'b0;
      r_hold     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_step <= 1'b0;
      r_hold <= 1'b0;
      r_err  <= 1'b0;
      if (en) begin
        case (r_fsm)
          FSM_IDLE: begin
            r_prev <= w_cur;
            r_fsm  <= FSM_ACQ;
          end
          FSM_ACQ, FSM_LOCKED: begin
            r_prev <= w_cur;
            case (w_cls)
              CL_HOLD: r_hold <= 1'b1;
              CL_ILL: begin
                r_err     <= 1'b1;
                r_err_cnt <= w_err_nxt;
                r_run_len <= '0;
                r_fsm     <= (w_err_nxt == MAX_ERR_C) ? FSM_FAULT : FSM_ACQ;
              end
              default: begin
                // A reversal restarts the run at 1, which also drops LOCKED.
                r_step     <= 1'b1;
                r_step_cnt <= w_cnt_step;
                r_dir      <= w_up;
                r_run_len  <= w_run_step;
                r_fsm      <= (w_run_step == LOCK_LEN_C) ? FSM_LOCKED : FSM_ACQ;
              end
            endcase
          end
          default: ; // FAULT: everything frozen until rst
        endcase
      end
    end
  end

  assign step     = r_step;
  assign dir      = r_dir;
  assign hold     = r_hold;
  assign err      = r_err;
  assign step_cnt = r_step_cnt;
  assign err_cnt  = r_err_cnt;
  assign locked   = (r_fsm == FSM_LOCKED);
  assign fault    = (r_fsm == FSM_FAULT);

endmodule

// File: tb/tb_mach_seq_monitor.sv
// -----------------------------------------------------------------------------
// tb_mach_seq_monitor
// Directed bench for mach_seq_monitor. Each driven cycle pushes the expected
// output set into a scoreboard queue; one edge later it is popped and compared.
// -----------------------------------------------------------------------------
module tb_mach_seq_monitor;
  import mach_pkg::*;

  typedef struct packed {
    logic       step;
    logic       dir;
    logic       hold;
    logic       err;
    logic [7:0] cnt;
    logic [1:0] ec;
    logic       locked;
    logic       fault;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en  = 1'b0;
  logic       a   = 1'b0;
  logic       b   = 1'b0;
  logic       step, dir, hold, err, locked, fault;
  logic [7:0] step_cnt;
  logic [1:0] err_cnt;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  mach_seq_monitor #(.CNT_W(8), .LOCK_LEN(4), .MAX_ERR(3)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .a        (a),
    .b        (b),
    .step     (step),
    .dir      (dir),
    .hold     (hold),
    .err      (err),
    .step_cnt (step_cnt),
    .err_cnt  (err_cnt),
    .locked   (locked),
    .fault    (fault)
  );

  always #5 clk = ~clk;

  function automatic exp_t mk(input logic s, input logic d, input logic h,
                              input logic e, input logic [7:0] c,
                              input logic [1:0] ec, input logic l, input logic f);
    exp_t x;
    x.step = s; x.dir = d; x.hold = h; x.err = e;
    x.cnt = c; x.ec = ec; x.locked = l; x.fault = f;
    return x;
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    n_chk++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, expv, $time);
  endtask

  task automatic compare_out(input string tag);
    exp_t x;
    if (sb.size() == 0) begin
      n_chk++;
      $error("FAIL %s scoreboard empty observed=none expected=entry", tag);
    end else begin
      x = sb.pop_front();
      chk({tag, ".step"},   8'(step),   8'(x.step));
      chk({tag, ".dir"},    8'(dir),    8'(x.dir));
      chk({tag, ".hold"},   8'(hold),   8'(x.hold));
      chk({tag, ".err"},    8'(err),    8'(x.err));
      chk({tag, ".cnt"},    step_cnt,   x.cnt);
      chk({tag, ".errcnt"}, 8'(err_cnt), 8'(x.ec));
      chk({tag, ".locked"}, 8'(locked), 8'(x.locked));
      chk({tag, ".fault"},  8'(fault),  8'(x.fault));
    end
  endtask

  // One clock: drive on the falling edge, compare 1 ns after the rising edge.
  task automatic cyc(input string tag, input logic r, input logic e,
                     input logic [1:0] ab, input exp_t x);
    @(negedge clk);
    rst = r; en = e; {a, b} = ab;
    sb.push_back(x);
    @(posedge clk);
    #1;
    compare_out(tag);
  endtask

  initial begin
    // Reset with en=1 also proves rst wins over en.
    cyc("reset0",   1, 1, S1, mk(0,0,0,0,  0,0,0,0));

    // Up run to lock.
    cyc("up_first", 0, 1, S0, mk(0,0,0,0,  0,0,0,0));
    cyc("up1",      0, 1, S1, mk(1,1,0,0,  1,0,0,0));
    cyc("up2",      0, 1, S2, mk(1,1,0,0,  2,0,0,0));
    cyc("up3",      0, 1, S3, mk(1,1,0,0,  3,0,0,0));
    cyc("up4_lock", 0, 1, S0, mk(1,1,0,0,  4,0,1,0));
    for (int i = 0; i < 5; i++)
      cyc("lock_hold", 0, 1, S0, mk(0,1,1,0, 4,0,1,0));
    // Reversal from LOCKED drops to ACQ, no error.
    cyc("rev1",     0, 1, S3, mk(1,0,0,0,  3,0,0,0));
    cyc("rev2",     0, 1, S2, mk(1,0,0,0,  2,0,0,0));

    // Re-lock, then reset mid-operation.
    cyc("rst_mid",  1, 0, S0, mk(0,0,0,0,  0,0,0,0));
    cyc("rl_first", 0, 1, S0, mk(0,0,0,0,  0,0,0,0));
    cyc("rl1",      0, 1, S1, mk(1,1,0,0,  1,0,0,0));
    cyc("rl2",      0, 1, S2, mk(1,1,0,0,  2,0,0,0));
    cyc("rl3",      0, 1, S3, mk(1,1,0,0,  3,0,0,0));
    cyc("rl4",      0, 1, S0, mk(1,1,0,0,  4,0,1,0));
    cyc("rst_lock", 1, 1, S0, mk(0,0,0,0,  0,0,0,0));
    cyc("post_rst", 0, 1, S1, mk(0,0,0,0,  0,0,0,0));

    // Down steps wrap below zero.
    cyc("rst_dn",   1, 0, S0, mk(0,0,0,0,  0,0,0,0));
    cyc("dn_first", 0, 1, S0, mk(0,0,0,0,  0,0,0,0));
    cyc("dn1_wrap", 0, 1, S3, mk(1,0,0,0,255,0,0,0));
    cyc("dn2",      0, 1, S2, mk(1,0,0,0,254,0,0,0));
    cyc("dn3",      0, 1, S1, mk(1,0,0,0,253,0,0,0));

    // Illegal jumps into FAULT.
    cyc("rst_ill",  1, 0, S0, mk(0,0,0,0,  0,0,0,0));
    cyc("il_first", 0, 1, S0, mk(0,0,0,0,  0,0,0,0));
    cyc("ill1",     0, 1, S2, mk(0,0,0,1,  0,1,0,0));
    cyc("ill_hold", 0, 1, S2, mk(0,0,1,0,  0,1,0,0));
    cyc("ill2",     0, 1, S0, mk(0,0,0,1,  0,2,0,0));
    cyc("ill3",     0, 1, S2, mk(0,0,0,1,  0,3,0,1));
    cyc("flt_up",   0, 1, S3, mk(0,0,0,0,  0,3,0,1));
    cyc("flt_up2",  0, 1, S0, mk(0,0,0,0,  0,3,0,1));
    cyc("flt_ill",  0, 1, S2, mk(0,0,0,0,  0,3,0,1));

    // Enable gating.
    cyc("rst_en",   1, 0, S0, mk(0,0,0,0,  0,0,0,0));
    cyc("en_first", 0, 1, S0, mk(0,0,0,0,  0,0,0,0));
    cyc("en_off1",  0, 0, S2, mk(0,0,0,0,  0,0,0,0));
    cyc("en_off2",  0, 0, S0, mk(0,0,0,0,  0,0,0,0));
    cyc("en_off3",  0, 0, S2, mk(0,0,0,0,  0,0,0,0));
    cyc("en_up",    0, 1, S1, mk(1,1,0,0,  1,0,0,0));
    cyc("en_off4",  0, 0, S3, mk(0,1,0,0,  1,0,0,0));
    cyc("en_up2",   0, 1, S2, mk(1,1,0,0,  2,0,0,0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
